sonar_ranger: RTL and testbench



---
 rtl/sonar_ranger.sv | 166 ++++++++++++++++
 tb/tb_sonar_ranger.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sonar_ranger.sv
// HC-SR04 ranging front end: issues the trigger pulse on a fixed period, times
// the synchronized echo pulse in whole centimetres and publishes the result
// (or a timeout indication) with a one-cycle valid strobe.
module sonar_ranger #(
  parameter int TRIG_CYCLES   = 270,
  parameter int PERIOD_CYCLES = 6750000,
  parameter int CYCLES_PER_CM = 1566,
  parameter int RISE_TIMEOUT  = 27000,
  parameter int ECHO_TIMEOUT  = 1080000,
  parameter int MAX_CM        = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ech,
  output logic       tk,
  output logic [6:0] distance_cm,
  output logic       dist_valid,
  output logic       no_echo,
  output logic       busy
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int WW = $clog2(RISE_TIMEOUT + 1);
  localparam int SW = $clog2(CYCLES_PER_CM + 1);
  localparam int EW = $clog2(ECHO_TIMEOUT + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(RISE_TIMEOUT - 1);
  localparam logic [SW-1:0] SUB_LAST    = SW'(CYCLES_PER_CM - 1);
  localparam logic [EW-1:0] ECHO_LAST   = EW'(ECHO_TIMEOUT - 1);
  localparam logic [6:0]    CM_MAX      = 7'(MAX_CM);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   period_cnt;
  logic [TW-1:0]   trig_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [SW-1:0]   sub_cnt, sub_base, sub_inc;
  logic [6:0]      cm_cnt, cm_base, cm_inc;
  logic [EW-1:0]   total_cnt, total_base, total_inc;
  logic            ech_q1, ech_s, ech_prev;
  logic            rise, fall, sub_wrap, count_en, echo_to, res_to;

  // Centimetre count saturates at MAX_CM instead of wrapping.
  function automatic logic [6:0] sat_inc_cm(input logic [6:0] v);
    return (v == CM_MAX) ? v : v + 7'd1;
  endfunction

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ech_q1   <= 1'b0;
      ech_s    <= 1'b0;
      ech_prev <= 1'b0;
    end else begin
      ech_q1   <= ech;
      ech_s    <= ech_q1;
      ech_prev <= ech_s;
    end
  end

  assign rise = ech_s & ~ech_prev;
  assign fall = ~ech_s & ech_prev;

  // Free-running trigger period counter; zero marks a trigger opportunity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // Echo-width arithmetic: the rise cycle is the first counted high cycle,
  // so counting starts from zero bases while still in WAIT_RISE.
  always_comb begin
    sub_base   = (state == MEASURE) ? sub_cnt   : '0;
    cm_base    = (state == MEASURE) ? cm_cnt    : '0;
    total_base = (state == MEASURE) ? total_cnt : '0;
    sub_wrap   = (sub_base == SUB_LAST);
    sub_inc    = sub_wrap ? '0 : sub_base + SW'(1);
    cm_inc     = sub_wrap ? sat_inc_cm(cm_base) : cm_base;
    total_inc  = total_base + EW'(1);
    count_en   = ((state == WAIT_RISE) && rise) || ((state == MEASURE) && ech_s);
    echo_to    = (state == MEASURE) && ech_s && (total_cnt == ECHO_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; a rise beats a simultaneous wait timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (period_cnt == '0) state_nxt = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST) state_nxt = WAIT_RISE;
      WAIT_RISE: begin
        if (rise)                        state_nxt = MEASURE;
        else if (wait_cnt == WAIT_LAST)  state_nxt = DONE;
      end
      MEASURE:   if (fall || echo_to) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from state.
  always_comb begin
    tk   = (state == TRIG);
    busy = (state != IDLE);
  end

  // Phase counters for trigger width, rise wait and echo width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_cnt  <= '0;
      wait_cnt  <= '0;
      sub_cnt   <= '0;
      cm_cnt    <= '0;
      total_cnt <= '0;
    end else begin
      trig_cnt <= (state == TRIG) ? trig_cnt + TW'(1) : '0;
      wait_cnt <= (state == WAIT_RISE) ? wait_cnt + WW'(1) : '0;
      if (count_en) begin
        sub_cnt   <= sub_inc;
        cm_cnt    <= cm_inc;
        total_cnt <= total_inc;
      end
    end
  end

  // Timeout flag: leaving WAIT_RISE without a rise, or MEASURE via echo_to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_to <= 1'b0;
    end else if (state == WAIT_RISE) begin
      res_to <= ~rise;
    end else if (state == MEASURE) begin
      res_to <= echo_to;
    end
  end

  // Result publication in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      distance_cm <= '0;
      no_echo     <= 1'b0;
      dist_valid  <= 1'b0;
    end else if (state == DONE) begin
      distance_cm <= res_to ? CM_MAX : cm_cnt;
      no_echo     <= res_to;
      dist_valid  <= 1'b1;
    end else begin
      dist_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sonar_ranger.sv
// Self-checking bench for sonar_ranger: directed scenarios plus randomized
// echo widths, compared against a distance/timeout model of the sensor rules.
module tb_sonar_ranger;

  localparam int TRIG   = 4;
  localparam int PERIOD = 3000;
  localparam int CPC    = 10;
  localparam int RISE_TO = 100;
  localparam int ECHO_TO = 1500;
  localparam int MAXCM  = 127;

  logic       clk = 1'b0;
  logic       rst;
  logic       ech;
  logic       tk;
  logic [6:0] distance_cm;
  logic       dist_valid;
  logic       no_echo;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int prev_rise = -1;
  bit dv_prev = 1'b0;
  int q_d[$];
  int q_ne[$];
  int q_c[$];

  sonar_ranger #(
    .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PERIOD), .CYCLES_PER_CM(CPC),
    .RISE_TIMEOUT(RISE_TO), .ECHO_TIMEOUT(ECHO_TO), .MAX_CM(MAXCM)
  ) dut (
    .clk(clk), .rst(rst), .ech(ech), .tk(tk), .distance_cm(distance_cm),
    .dist_valid(dist_valid), .no_echo(no_echo), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    assert (PERIOD > TRIG + RISE_TO + ECHO_TO + 4)
      else $error("parameter relation violated");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Sensor rules: W high cycles -> floor(W/CPC) saturated; no rise or
  // W reaching ECHO_TO -> timeout reported as MAXCM with no_echo.
  function automatic void ref_model(input int hi, output int d, output int ne);
    if (hi == 0 || hi >= ECHO_TO) begin
      d = MAXCM; ne = 1;
    end else begin
      d = hi / CPC;
      if (d > MAXCM) d = MAXCM;
      ne = 0;
    end
  endfunction

  // Capture every result strobe and confirm it never lasts two cycles.
  always @(negedge clk) begin
    if (rst) begin
      dv_prev = 1'b0;
    end else begin
      if (dist_valid) begin
        chk("dv_one_cycle", int'(dv_prev), 0);
        q_d.push_back(int'(distance_cm));
        q_ne.push_back(int'(no_echo));
        q_c.push_back(cyc);
      end
      dv_prev = dist_valid;
    end
  end

  task automatic run_meas(input string name, input bit pre, input int dly, input int hi);
    int n, t_fall, t_rise, t_edge, exp_d, exp_ne, got_d, got_ne, got_c;
    if (pre) ech = 1'b1;
    n = 0;
    while (!tk && n < 4000) begin @(negedge clk); n++; end
    if (!tk) begin chk({name, "_tk_rise"}, 0, 1); return; end
    if (prev_rise >= 0) chk({name, "_period"}, cyc - prev_rise, PERIOD);
    prev_rise = cyc;
    n = 0;
    while (tk && n < 100) begin @(negedge clk); n++; end
    chk({name, "_tk_width"}, n, TRIG);
    chk({name, "_busy"}, int'(busy), 1);
    t_fall = cyc;
    t_rise = 0;
    t_edge = 0;
    if (pre) begin repeat (50) @(negedge clk); ech = 1'b0; end
    if (hi > 0) begin
      repeat (dly) @(negedge clk);
      ech = 1'b1; t_rise = cyc;
      repeat (hi) @(negedge clk);
      ech = 1'b0; t_edge = cyc;
    end
    n = 0;
    while (q_c.size() == 0 && n < 2000) begin @(negedge clk); n++; end
    if (q_c.size() == 0) begin chk({name, "_dv_seen"}, 0, 1); return; end
    got_d = q_d.pop_front(); got_ne = q_ne.pop_front(); got_c = q_c.pop_front();
    ref_model(hi, exp_d, exp_ne);
    chk({name, "_dist"}, got_d, exp_d);
    chk({name, "_no_echo"}, got_ne, exp_ne);
    if (hi == 0)
      chk({name, "_rise_to_lat"}, int'(got_c >= t_fall + 99 && got_c <= t_fall + 103), 1);
    else if (exp_ne == 1)
      chk({name, "_echo_to_lat"}, int'(got_c >= t_rise + 1500 && got_c <= t_rise + 1506), 1);
    else
      chk({name, "_fall_lat"}, got_c - t_edge, 4);
  endtask

  initial begin
    int mode, hi, dly;
    rst = 1'b1;
    ech = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tk", int'(tk), 0);
    chk("rst_dist", int'(distance_cm), 0);
    chk("rst_dv", int'(dist_valid), 0);
    chk("rst_no_echo", int'(no_echo), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tk_first_edge", int'(tk), 1);

    run_meas("no_rise", 1'b0, 0, 0);
    run_meas("normal", 1'b0, 20, 255);
    run_meas("saturate", 1'b0, 20, 1400);
    run_meas("echo_to", 1'b0, 20, 1600);
    run_meas("stuck", 1'b1, 10, 100);

    for (int i = 0; i < 6; i++) begin
      mode = $urandom_range(0, 9);
      dly = $urandom_range(0, 60);
      if (mode == 0)      hi = 0;
      else if (mode == 1) hi = $urandom_range(1600, 1800);
      else                hi = $urandom_range(1, 1499);
      run_meas($sformatf("rnd%0d", i), 1'b0, dly, hi);
    end

    // Reset 30 cycles into a 255-cycle echo.
    while (!tk) @(negedge clk);
    while (tk) @(negedge clk);
    repeat (20) @(negedge clk);
    ech = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_tk", int'(tk), 0);
    chk("mid_rst_dist", int'(distance_cm), 0);
    chk("mid_rst_dv", int'(dist_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    q_d.delete(); q_ne.delete(); q_c.delete();
    repeat (3) @(negedge clk);
    ech = 1'b0;
    rst = 1'b0;
    prev_rise = -1;
    @(negedge clk);
    chk("tk_after_rst", int'(tk), 1);
    run_meas("post_rst", 1'b0, 20, 120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
